food_gen_ctrl: RTL and testbench

FOOD_GEN_CTRL -- requirements
Module: food_gen_ctrl

---
 rtl/snake_pkg.sv | 27 ++
 rtl/snake_lfsr16.sv | 31 +++
 rtl/food_gen_ctrl.sv | 158 +++++++++++++++
 tb/tb_food_gen_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game blocks: grid geometry,
// default food cell and the food generator state encoding.
package snake_pkg;

    localparam int unsigned SNAKE_GRID_W = 32;
    localparam int unsigned SNAKE_GRID_H = 24;
    localparam int unsigned COORD_W      = 5;
    localparam int unsigned ATT_W        = 7;

    localparam logic [COORD_W-1:0] FOOD_X_RST = 5'd16;
    localparam logic [COORD_W-1:0] FOOD_Y_RST = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_QUERY = 2'd2,
        ST_DONE  = 2'd3
    } food_state_e;

    function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int unsigned        w,
                                     input int unsigned        h);
        return (32'(x) < w) && (32'(y) < h);
    endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting), reloaded with SEED on reset.
module snake_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/food_gen_ctrl.sv
// Food placement controller: draws pseudo-random cells, checks each against the
// snake body memory and commits the first free one as the new food position.
module food_gen_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = SNAKE_GRID_W,
    parameter int unsigned GRID_H    = SNAKE_GRID_H,
    parameter int unsigned MAX_TRIES = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gen_req,
    output logic               gen_done,
    output logic               gen_fail,
    output logic               q_valid,
    output logic [COORD_W-1:0] q_x,
    output logic [COORD_W-1:0] q_y,
    input  logic               q_ack,
    input  logic               q_hit,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic               food_valid
);

    food_state_e        state_q, state_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    logic [COORD_W-1:0] cand_x_q, cand_x_d;
    logic [COORD_W-1:0] cand_y_q, cand_y_d;
    logic [COORD_W-1:0] food_x_q, food_x_d;
    logic [COORD_W-1:0] food_y_q, food_y_d;
    logic               food_valid_q, food_valid_d;
    logic               fail_q, fail_d;

    logic [15:0]        lfsr;
    logic [5:0]         lfsr_unused;
    logic [COORD_W-1:0] draw_x;
    logic [COORD_W-1:0] draw_y;
    logic [ATT_W-1:0]   att_inc;
    logic               draw_reject;
    logic               draw_last;
    logic               query_last;

    snake_lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (16'hB400)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    assign draw_x      = lfsr[COORD_W-1:0];
    assign draw_y      = lfsr[2*COORD_W-1:COORD_W];
    assign lfsr_unused = lfsr[15:10];

    // A candidate is thrown away without a query if it lies off-grid or would
    // leave the food where it already is.
    assign draw_reject = !in_grid(draw_x, draw_y, GRID_W, GRID_H) ||
                         (food_valid_q && (draw_x == food_x_q) && (draw_y == food_y_q));
    assign att_inc     = attempts_q + ATT_W'(1);
    assign draw_last   = (32'(att_inc) >= MAX_TRIES);
    assign query_last  = (32'(attempts_q) >= MAX_TRIES);

    always_comb begin
        state_d      = state_q;
        attempts_d   = attempts_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        fail_d       = fail_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gen_req) begin
                    state_d    = ST_DRAW;
                    attempts_d = '0;
                    fail_d     = 1'b0;
                end
            end
            ST_DRAW: begin
                if (!gen_req) begin
                    state_d = ST_IDLE;
                end else begin
                    cand_x_d   = draw_x;
                    cand_y_d   = draw_y;
                    attempts_d = att_inc;
                    if (!draw_reject) begin
                        state_d = ST_QUERY;
                    end else if (draw_last) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end
                end
            end
            ST_QUERY: begin
                // Dropping the request wins over an ack arriving in the same cycle.
                if (!gen_req) begin
                    state_d = ST_IDLE;
                end else if (q_ack) begin
                    if (!q_hit) begin
                        state_d      = ST_DONE;
                        food_x_d     = cand_x_q;
                        food_y_d     = cand_y_q;
                        food_valid_d = 1'b1;
                    end else if (query_last) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAW;
                    end
                end
            end
            ST_DONE: begin
                if (!gen_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            attempts_q   <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= FOOD_X_RST;
            food_y_q     <= FOOD_Y_RST;
            food_valid_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            attempts_q   <= attempts_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            fail_q       <= fail_d;
        end
    end

    assign q_valid    = (state_q == ST_QUERY);
    assign gen_done   = (state_q == ST_DONE);
    assign gen_fail   = (state_q == ST_DONE) && fail_q;
    assign q_x        = cand_x_q;
    assign q_y        = cand_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;

endmodule

// File: tb/tb_food_gen_ctrl.sv
// Bench for food_gen_ctrl: directed scenarios plus a long randomized run,
// checked against an LFSR-driven reference model of the placement rules.
module tb_food_gen_ctrl;

    localparam int          GRID_H_T = 24;
    localparam int          MAXT     = 64;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic       clk;
    logic       rst;
    logic       gen_req;
    logic       gen_done;
    logic       gen_fail;
    logic       q_valid;
    logic [4:0] q_x;
    logic [4:0] q_y;
    logic       q_ack;
    logic       q_hit;
    logic [4:0] food_x;
    logic [4:0] food_y;
    logic       food_valid;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    logic [4:0]  mfx;
    logic [4:0]  mfy;
    logic        mfv;
    logic [9:0]  pred_q[$];

    food_gen_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .gen_req    (gen_req),
        .gen_done   (gen_done),
        .gen_fail   (gen_fail),
        .q_valid    (q_valid),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_ack      (q_ack),
        .q_hit      (q_hit),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR: seeded by reset, advanced on every rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lstep(m_lfsr);
    end

    function automatic bit cand_ok(input logic [15:0] v);
        return (int'(v[9:5]) < GRID_H_T) && !(mfv && v[4:0] == mfx && v[9:5] == mfy);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predicts one generation started with request raised while the LFSR holds l0,
    // acks given in the same cycle, first nhits queries answered as occupied.
    // Cycle 1 is the first cycle after the edge that sees the request.
    task automatic predict(input logic [15:0] l0, input int nhits,
                           output int lat, output bit pfail);
        logic [15:0] l;
        int cyc;
        int att;
        l = lstep(l0);
        cyc = 1;
        att = 0;
        lat = 0;
        pfail = 1'b0;
        pred_q.delete();
        for (int k = 0; k < 1000; k++) begin
            att++;
            if (!cand_ok(l)) begin
                if (att >= MAXT) begin
                    pfail = 1'b1;
                    lat = cyc + 1;
                    return;
                end
                l = lstep(l);
                cyc++;
            end else begin
                pred_q.push_back(l[9:0]);
                if (pred_q.size() > nhits) begin
                    lat = cyc + 2;
                    return;
                end
                if (att >= MAXT) begin
                    pfail = 1'b1;
                    lat = cyc + 2;
                    return;
                end
                l = lstep(lstep(l));
                cyc += 2;
            end
        end
    endtask

    task automatic run_gen(input string tag, input int nhits, input int budget);
        int lat;
        int nq;
        int done_cyc;
        bit pfail;
        logic [9:0] obs[$];
        logic [9:0] last;
        predict(m_lfsr, nhits, lat, pfail);
        gen_req = 1'b1;
        q_ack = 1'b1;
        q_hit = 1'b0;
        nq = 0;
        done_cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (q_valid) begin
                obs.push_back({q_y, q_x});
                nq++;
                q_hit = (nq <= nhits);
            end
            if (gen_done) begin
                done_cyc = c;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(done_cyc != 0), 32'd1);
        chk({tag, "_latency"}, done_cyc, lat);
        chk({tag, "_gen_fail"}, 32'(gen_fail), 32'(pfail));
        chk({tag, "_qv_excl"}, 32'(q_valid), 32'd0);
        chk({tag, "_nqueries"}, obs.size(), pred_q.size());
        for (int i = 0; i < obs.size() && i < pred_q.size(); i++) begin
            chk($sformatf("%s_query%0d", tag, i), 32'(obs[i]), 32'(pred_q[i]));
        end
        if (!pfail && pred_q.size() > 0) begin
            last = pred_q[pred_q.size() - 1];
            mfx = last[4:0];
            mfy = last[9:5];
            mfv = 1'b1;
        end
        chk({tag, "_food_x"}, 32'(food_x), 32'(mfx));
        chk({tag, "_food_y"}, 32'(food_y), 32'(mfy));
        chk({tag, "_food_valid"}, 32'(food_valid), 32'(mfv));
        gen_req = 1'b0;
        q_ack = 1'b0;
        q_hit = 1'b0;
        @(negedge clk);
        chk({tag, "_release"}, 32'(gen_done), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit pfail;
        bit got;
        logic [9:0] exp0;
        bit r_done, r_excl, r_bady, r_unst;
        int dly;
        logic [9:0] held;
        logic [9:0] acked;

        rst = 1'b1;
        gen_req = 1'b0;
        q_ack = 1'b0;
        q_hit = 1'b0;
        mfx = 5'd16;
        mfy = 5'd12;
        mfv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gen_done", 32'(gen_done), 32'd0);
        chk("rst_gen_fail", 32'(gen_fail), 32'd0);
        chk("rst_q_valid", 32'(q_valid), 32'd0);
        chk("rst_q_x", 32'(q_x), 32'd0);
        chk("rst_q_y", 32'(q_y), 32'd0);
        chk("rst_food_x", 32'(food_x), 32'd16);
        chk("rst_food_y", 32'(food_y), 32'd12);
        chk("rst_food_valid", 32'(food_valid), 32'd0);
        rst = 1'b0;

        run_gen("clean", 0, 200);
        run_gen("collide", 3, 200);
        run_gen("exhaust", 100000, 1000);

        // Stall with ack held low, then drop the request while querying.
        predict(m_lfsr, 100000, lat, pfail);
        exp0 = (pred_q.size() > 0) ? pred_q[0] : 10'h3ff;
        gen_req = 1'b1;
        q_ack = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall_reached", 32'(got), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("stall_qv_c%0d", i), 32'(q_valid), 32'd1);
            chk($sformatf("stall_qxy_c%0d", i), 32'({q_y, q_x}), 32'(exp0));
        end
        gen_req = 1'b0;
        q_ack = 1'b1;
        @(negedge clk);
        chk("abort_q_valid", 32'(q_valid), 32'd0);
        chk("abort_gen_done", 32'(gen_done), 32'd0);
        chk("abort_food", 32'({food_valid, food_y, food_x}), 32'({mfv, mfy, mfx}));
        q_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle_done", 32'(gen_done), 32'd0);
        chk("abort_idle_qv", 32'(q_valid), 32'd0);

        // Reset while a query is outstanding.
        gen_req = 1'b1;
        q_ack = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstq_reached", 32'(got), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstq_q_valid", 32'(q_valid), 32'd0);
        chk("rstq_gen_done", 32'(gen_done), 32'd0);
        chk("rstq_food_x", 32'(food_x), 32'd16);
        chk("rstq_food_y", 32'(food_y), 32'd12);
        chk("rstq_food_valid", 32'(food_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        gen_req = 1'b0;
        mfx = 5'd16;
        mfy = 5'd12;
        mfv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstq_idle_qv", 32'(q_valid), 32'd0);
        chk("rstq_idle_done", 32'(gen_done), 32'd0);
        run_gen("post_rst", 0, 200);

        // Long randomized run with variable ack latency and occasional hits.
        for (int g = 0; g < 10000; g++) begin
            gen_req = 1'b1;
            q_ack = 1'b0;
            q_hit = 1'b0;
            dly = $urandom_range(0, 1);
            r_done = 1'b0;
            r_excl = 1'b0;
            r_bady = 1'b0;
            r_unst = 1'b0;
            held = 10'h3ff;
            acked = 10'h3ff;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (q_valid && gen_done) r_excl = 1'b1;
                if (gen_done) begin
                    r_done = 1'b1;
                    break;
                end
                if (q_valid) begin
                    if (int'(q_y) >= GRID_H_T) r_bady = 1'b1;
                    if (held != 10'h3ff && {q_y, q_x} != held) r_unst = 1'b1;
                    if (dly == 0) begin
                        q_ack = 1'b1;
                        q_hit = ($urandom_range(0, 7) == 0);
                        if (!q_hit) acked = {q_y, q_x};
                        held = 10'h3ff;
                        dly = $urandom_range(0, 1);
                    end else begin
                        q_ack = 1'b0;
                        held = {q_y, q_x};
                        dly--;
                    end
                end else begin
                    q_ack = 1'b0;
                    held = 10'h3ff;
                end
            end
            chk("rng_done_seen", 32'(r_done), 32'd1);
            chk("rng_excl", 32'(r_excl), 32'd0);
            chk("rng_q_y_range", 32'(r_bady), 32'd0);
            chk("rng_q_stable", 32'(r_unst), 32'd0);
            if (r_done && !gen_fail) begin
                chk("rng_no_repeat", 32'(mfv && acked == {mfy, mfx}), 32'd0);
                mfx = acked[4:0];
                mfy = acked[9:5];
                mfv = 1'b1;
            end
            chk("rng_food", 32'({food_valid, food_y, food_x}), 32'({mfv, mfy, mfx}));
            gen_req = 1'b0;
            q_ack = 1'b0;
            q_hit = 1'b0;
            @(negedge clk);
            chk("rng_release", 32'(gen_done), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
